// File: rtl/alu_pkg.sv
// Shared constants for the RV32I register-file/ALU datapath:
// datapath width, register-index width and ALU opcodes.
package alu_pkg;

  localparam int XLEN  = 32;
  localparam int RIDXW = 5;

  localparam logic [4:0] IADD  = 5'd0;
  localparam logic [4:0] ISUB  = 5'd1;
  localparam logic [4:0] IAND  = 5'd2;
  localparam logic [4:0] IOR   = 5'd3;
  localparam logic [4:0] IXOR  = 5'd4;
  localparam logic [4:0] ISLL  = 5'd5;
  localparam logic [4:0] ISRL  = 5'd6;
  localparam logic [4:0] ISRA  = 5'd7;
  localparam logic [4:0] ISLT  = 5'd8;
  localparam logic [4:0] ISLTU = 5'd9;

endpackage

// File: rtl/rv32_alu_core.sv
// Combinational RV32I integer ALU; undefined opcodes yield zero.
// Stateless: no clock or reset.
module rv32_alu_core
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [4:0]      op_i,
  output logic [XLEN-1:0] y_o,
  output logic            zero_o
);

  logic [4:0] shamt;

  assign shamt = b_i[4:0];

  always_comb begin
    y_o = '0;
    case (op_i)
      IADD:  y_o = a_i + b_i;
      ISUB:  y_o = a_i - b_i;
      IAND:  y_o = a_i & b_i;
      IOR:   y_o = a_i | b_i;
      IXOR:  y_o = a_i ^ b_i;
      ISLL:  y_o = a_i << shamt;
      ISRL:  y_o = a_i >> shamt;
      ISRA:  y_o = $unsigned($signed(a_i) >>> shamt);
      ISLT:  y_o = {31'b0, $signed(a_i) < $signed(b_i)};
      ISLTU: y_o = {31'b0, a_i < b_i};
      default: y_o = '0;
    endcase
  end

  assign zero_o = (y_o == '0);

endmodule

// File: rtl/rv32_rf_alu.sv
// RV32I 32x32 register file (2R/1W, x0 hardwired) plus combinational ALU.
// Define RF_BYPASS_EN for same-cycle write-through to the read ports.
module rv32_rf_alu #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [alu_pkg::RIDXW-1:0] RNUM1,
  output logic [XLEN-1:0]           RDATA1,
  input  logic [alu_pkg::RIDXW-1:0] RNUM2,
  output logic [XLEN-1:0]           RDATA2,
  input  logic                      WE,
  input  logic [alu_pkg::RIDXW-1:0] WNUM,
  input  logic [XLEN-1:0]           WDATA,
  input  logic [XLEN-1:0]           A,
  input  logic [XLEN-1:0]           B,
  input  logic [4:0]                C,
  output logic [XLEN-1:0]           Y,
  output logic                      ZERO
);

  logic [XLEN-1:0] rf_q [NREG];
  logic            wr_en;

  assign wr_en = WE && (WNUM != '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wr_en) begin
      rf_q[WNUM] <= WDATA;
    end
  end

  always_comb begin
    RDATA1 = rf_q[RNUM1];
    RDATA2 = rf_q[RNUM2];
`ifdef RF_BYPASS_EN
    if (wr_en && RNUM1 == WNUM) RDATA1 = WDATA;
    if (wr_en && RNUM2 == WNUM) RDATA2 = WDATA;
`endif
    // reset forces zero even on a bypassed read
    if (RST || RNUM1 == '0) RDATA1 = '0;
    if (RST || RNUM2 == '0) RDATA2 = '0;
  end

  rv32_alu_core u_alu (
    .a_i    (A),
    .b_i    (B),
    .op_i   (C),
    .y_o    (Y),
    .zero_o (ZERO)
  );

endmodule

// File: tb/tb_rv32_rf_alu.sv
// Self-checking bench for rv32_rf_alu: directed plus randomized
// register-file and ALU traffic against a behavioural model.
module tb_rv32_rf_alu;

  logic        CLK = 0;
  logic        RST;
  logic [4:0]  RNUM1, RNUM2, WNUM;
  logic [31:0] RDATA1, RDATA2, WDATA, A, B, Y;
  logic        WE, ZERO;
  logic [4:0]  C;

  int errors = 0;
  int checks = 0;
  logic [31:0] model [32];

  rv32_rf_alu dut (
    .CLK(CLK), .RST(RST),
    .RNUM1(RNUM1), .RDATA1(RDATA1),
    .RNUM2(RNUM2), .RDATA2(RDATA2),
    .WE(WE), .WNUM(WNUM), .WDATA(WDATA),
    .A(A), .B(B), .C(C), .Y(Y), .ZERO(ZERO)
  );

  always #5 CLK = ~CLK;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  function automatic logic [31:0] ref_alu(
    input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    longint unsigned ua, ub, p;
    longint sa, sb;
    int sh;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    p  = 64'd1 << sh;
    case (op)
      5'd0: return 32'((ua + ub) % (64'd1 << 32));
      5'd1: return 32'((ua + (64'd1 << 32) - ub) % (64'd1 << 32));
      5'd2: return a & b;
      5'd3: return a | b;
      5'd4: return a ^ b;
      5'd5: return 32'((ua * p) % (64'd1 << 32));
      5'd6: return 32'(ua / p);
      5'd7: begin
        if (sa < 0) return 32'(-((-sa + longint'(p) - 1) / longint'(p)));
        return 32'(sa / longint'(p));
      end
      5'd8: return (sa < sb) ? 32'd1 : 32'd0;
      5'd9: return (ua < ub) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (BYP && WE && WNUM != 0 && WNUM == r) return WDATA;
    return model[r];
  endfunction

  task automatic idle();
    WE = 0; WNUM = 0; WDATA = 0; RNUM1 = 0; RNUM2 = 0;
  endtask

  task automatic write_reg(input logic [4:0] r, input logic [31:0] d);
    @(negedge CLK);
    WE = 1; WNUM = r; WDATA = d;
    @(posedge CLK);
    if (r != 0) model[r] = d;
    #1 WE = 0;
  endtask

  task automatic test_reset();
    idle();
    A = 0; B = 0; C = 0;
    RST = 1;
    #3;
    for (int i = 0; i < 32; i++) begin
      RNUM1 = 5'(i); RNUM2 = 5'(31 - i);
      #1;
      checks++;
      if (RDATA1 !== 0 || RDATA2 !== 0) begin
        errors++;
        $display("FAIL reset_read r%0d: got %h/%h want 0", i, RDATA1, RDATA2);
      end
    end
    for (int i = 0; i < 32; i++) model[i] = 0;
    @(negedge CLK);
    RST = 0;
  endtask

  task automatic test_x0();
    write_reg(5'd0, 32'hDEADBEEF);
    @(negedge CLK);
    RNUM1 = 0; RNUM2 = 0;
    #1;
    checks++;
    if (RDATA1 !== 0 || RDATA2 !== 0) begin
      errors++;
      $display("FAIL x0_write: got %h/%h want 0", RDATA1, RDATA2);
    end
  endtask

  task automatic test_write_read();
    write_reg(5'd5, 32'h12345678);
    write_reg(5'd6, 32'hFFFF0000);
    @(negedge CLK);
    RNUM1 = 5; RNUM2 = 6;
    #1;
    checks++;
    if (RDATA1 !== 32'h12345678 || RDATA2 !== 32'hFFFF0000) begin
      errors++;
      $display("FAIL write_read: got %h/%h want 12345678/ffff0000",
               RDATA1, RDATA2);
    end
    @(negedge CLK);
    WE = 0; WNUM = 5; WDATA = 32'hAAAA5555;
    @(posedge CLK);
    #1;
    RNUM1 = 5; RNUM2 = 5;
    #1;
    checks++;
    if (RDATA1 !== 32'h12345678 || RDATA2 !== 32'h12345678) begin
      errors++;
      $display("FAIL we_low: got %h/%h want 12345678", RDATA1, RDATA2);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp;
    write_reg(5'd7, 32'd1);
    @(negedge CLK);
    WE = 1; WNUM = 7; WDATA = 32'd2; RNUM1 = 7; RNUM2 = 7;
    exp = BYP ? 32'd2 : 32'd1;
    #1;
    checks++;
    if (RDATA1 !== exp || RDATA2 !== exp) begin
      errors++;
      $display("FAIL same_cycle: got %h/%h want %h", RDATA1, RDATA2, exp);
    end
    @(posedge CLK);
    model[7] = 2;
    #1 WE = 0;
    #1;
    checks++;
    if (RDATA1 !== 32'd2) begin
      errors++;
      $display("FAIL after_write: got %h want 2", RDATA1);
    end
  endtask

  task automatic test_rst_mid();
    @(negedge CLK);
    WE = 1; WNUM = 9; WDATA = 32'h5A5A5A5A; RNUM1 = 5; RNUM2 = 9;
    RST = 1;
    @(posedge CLK);
    #1;
    checks++;
    if (RDATA1 !== 0 || RDATA2 !== 0) begin
      errors++;
      $display("FAIL rst_mid_high: got %h/%h want 0", RDATA1, RDATA2);
    end
    WE = 0;
    RST = 0;
    for (int i = 0; i < 32; i++) model[i] = 0;
    #1;
    checks++;
    if (RDATA1 !== 0 || RDATA2 !== 0) begin
      errors++;
      $display("FAIL rst_mid_after: got %h/%h want 0", RDATA1, RDATA2);
    end
  endtask

  task automatic test_alu_directed();
    logic [31:0] ta [13];
    logic [31:0] tb [13];
    logic [4:0]  tc [13];
    logic [31:0] ty [13];
    ta = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'h80000000, 32'h80000000, 32'h80000000,
           32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
           32'h0000000F, 32'h12345678};
    tb = '{32'd1, 32'd7, 32'd1, 32'd1,
           32'h24, 32'h24, 32'h24,
           32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0,
           32'hFFFFFFE1, 32'h1};
    tc = '{5'd0, 5'd1, 5'd8, 5'd9, 5'd6, 5'd7, 5'd5,
           5'd2, 5'd3, 5'd4, 5'd31, 5'd5, 5'd15};
    ty = '{32'h0, 32'hFFFFFFFE, 32'h1, 32'h0,
           32'h08000000, 32'hF8000000, 32'h0,
           32'h00F000F0, 32'hFFF0FFF0, 32'hFF00FF00, 32'h0,
           32'h1E, 32'h0};
    for (int i = 0; i < 13; i++) begin
      A = ta[i]; B = tb[i]; C = tc[i];
      #1;
      checks++;
      if (Y !== ty[i] || ZERO !== (ty[i] == 0)) begin
        errors++;
        $display("FAIL alu_dir%0d op%0d: got %h z%b want %h", i, tc[i],
                 Y, ZERO, ty[i]);
      end
    end
  endtask

  task automatic test_alu_random();
    logic [31:0] e;
    for (int i = 0; i < 300; i++) begin
      A = $urandom; B = $urandom;
      C = (i % 5 == 0) ? 5'($urandom) : 5'($urandom_range(0, 9));
      if (i % 7 == 0) B = A;
      e = ref_alu(A, B, C);
      #1;
      checks++;
      if (Y !== e || ZERO !== (e == 0)) begin
        errors++;
        $display("FAIL alu_rand op%0d a=%h b=%h: got %h z%b want %h",
                 C, A, B, Y, ZERO, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e1, e2;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      WE = ($urandom_range(0, 3) != 0);
      WNUM = 5'($urandom);
      WDATA = $urandom;
      RNUM1 = 5'($urandom);
      RNUM2 = (i % 4 == 0) ? RNUM1 : 5'($urandom);
      if (i % 6 == 0) RNUM1 = WNUM;
      e1 = ref_read(RNUM1);
      e2 = ref_read(RNUM2);
      #1;
      checks++;
      if (RDATA1 !== e1 || RDATA2 !== e2) begin
        errors++;
        $display("FAIL rf_rand r%0d/r%0d: got %h/%h want %h/%h",
                 RNUM1, RNUM2, RDATA1, RDATA2, e1, e2);
      end
      @(posedge CLK);
      if (WE && WNUM != 0) model[WNUM] = WDATA;
    end
    @(negedge CLK);
    idle();
  endtask

  initial begin
    test_reset();
    test_x0();
    test_write_read();
    test_same_cycle();
    test_rst_mid();
    test_alu_directed();
    test_alu_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32_rf_alu.md
Name: rv32_rf_alu

Overview:
- Datapath core of the 5-stage RV32I pipeline: a 32x32-bit integer register file plus a combinational 32-bit ALU, packaged as one block.
- ID stage reads rs1/rs2 through the register file.
- WB stage writes rd through the register file.
- EX stage drives the ALU operands and opcode.
- No pipeline registers inside; all staging lives in the surrounding pipeline.

Parameters:
- XLEN, 32, datapath width (only 32 supported).
- NREG, 32, number of architectural registers (x0..x31).

Ports:
- CLK  input  1  clock; register file writes on rising edge.
- RST  input  1  reset, asynchronous, active-high; clears all registers.
- RNUM1  input  5  read-port-1 register index (rs1).
- RDATA1  output  32  read-port-1 data.
- RNUM2  input  5  read-port-2 register index (rs2).
- RDATA2  output  32  read-port-2 data.
- WE  input  1  write enable.
- WNUM  input  5  write register index (rd).
- WDATA  input  32  write data.
- A  input  32  ALU operand A.
- B  input  32  ALU operand B.
- C  input  5  ALU operation code (alu_pkg encoding).
- Y  output  32  ALU result.
- ZERO  output  1  high when Y == 0.

Behaviour:
- Register file: 32 entries x 32 bits.
- Reads are combinational (zero latency): RDATAn = reg[RNUMn].
- Write occurs at posedge CLK when WE=1 and WNUM!=0: reg[WNUM] <= WDATA.
- x0 always reads 0; writes to x0 are discarded.
- Both read ports are fully independent; RNUM1==RNUM2 returns the same value on both.
- Read of the register being written in the same cycle returns the OLD value unless RF_BYPASS_EN is defined.
- RST asserted (any time, including mid-write): all registers become 0 immediately. A write coinciding with RST is dropped. RDATA1/RDATA2 read 0 while RST is high.
- ALU is purely combinational; Y valid in the same cycle as A/B/C. ALU has no state and ignores CLK/RST.
- Opcodes:
  - IADD: A+B, mod 2^32, carry discarded.
  - ISUB: A-B, mod 2^32.
  - IAND/IOR/IXOR: bitwise.
  - ISLL: A << B[4:0].
  - ISRL: logical right shift by B[4:0].
  - ISRA: arithmetic right shift by B[4:0], sign of A[31] replicated.
  - ISLT: Y = {31'b0, signed(A) < signed(B)}.
  - ISLTU: Y = {31'b0, A < B unsigned}.
- Shift amounts use only B[4:0]; B[31:5] are ignored.
- Any undefined C value: Y = 0.
- ZERO = (Y == 32'h0) for every opcode.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: if WE=1, WNUM!=0 and RNUMn==WNUM, RDATAn = WDATA combinationally (write-through), so a WB-stage write is visible to the ID-stage read in the same cycle.
- Not defined: reads return the stored value; the new value is visible from the next cycle.
- x0 reads 0 in both cases.

Decomposition:
- alu_pkg holds the 5-bit opcode localparams: IADD=0, ISUB=1, IAND=2, IOR=3, IXOR=4, ISLL=5, ISRL=6, ISRA=7, ISLT=8, ISLTU=9.
- alu_pkg also holds XLEN and the register-index width (5).
- One natural sub-module, rv32_alu_core (combinational ALU). The register file stays inline in rv32_rf_alu.

Test Plan:
- Reset/x0: assert RST, read all 32 indices -> all 0. Write x0=32'hDEADBEEF -> RDATA1 reads 0.
- Write/read: write x5=32'h12345678 at one edge, then x6=32'hFFFF0000. Next cycle RNUM1=5, RNUM2=6 -> 32'h12345678 and 32'hFFFF0000. WE=0 with WNUM=5 and other data -> x5 unchanged.
- Same-cycle read/write of x7 (old 1, new 2) -> RDATA1=1 without RF_BYPASS_EN, 2 with it.
- Arithmetic:
  - IADD 32'hFFFFFFFF+1 -> Y=0, ZERO=1.
  - ISUB 5-7 -> 32'hFFFFFFFE.
  - ISLT 32'hFFFFFFFF vs 1 -> 1.
  - ISLTU same operands -> 0.
- Shifts with A=32'h80000000, B=32'h00000024 (shamt 4):
  - ISRL -> 32'h08000000.
  - ISRA -> 32'hF8000000.
  - ISLL -> 0, ZERO=1.
- Logic: A=32'hF0F0F0F0, B=32'h0FF00FF0 -> IAND 32'h00F000F0, IOR 32'hFFF0FFF0, IXOR 32'hFF00FF00. C=31 -> Y=0.
